// File: rtl/game_round_timer.sv
// ---------------------------------------------------------------------------
// game_round_timer
//
// Counts a MM:SS round down at one tick per second and reports who won.
// A round starts on a rising edge of game_started. It ends in one of two ways:
// the hider is caught (winner=0), or time runs out (winner=1).
// The BCD digits drive the seven-segment/OLED overlay.
//
// Optional feature macro: GAME_PAUSE_EN
//   When defined, the game_pause port exists and freezes the countdown
//   while it is high in RUN.
//
// Parameters:
//   TICK_CYCLES   clk cycles per one-second tick
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   game_started   level, high while the menu is in its game state
//   time_setting   round length in minutes, sampled at round start
//   seeker_caught  single-cycle pulse when the hider is caught
//   game_pause     (GAME_PAUSE_EN only) level, freezes the countdown
//   game_done      round over, held until game_started falls
//   winner         1 = hider wins (time expired), 0 = seeker wins (caught)
//   running        high while the countdown is active
//   warn           high in RUN while remaining time <= 0:10
//   min_ones       BCD minutes digit
//   sec_tens       BCD seconds tens digit
//   sec_ones       BCD seconds ones digit
// ---------------------------------------------------------------------------
module game_round_timer #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_started,
    input  logic [7:0] time_setting,
    input  logic       seeker_caught,
`ifdef GAME_PAUSE_EN
    input  logic       game_pause,
`endif
    output logic       game_done,
    output logic       winner,
    output logic       running,
    output logic       warn,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          started_q;
    logic          armed;
    logic [11:0]   time_bcd;   // {min_ones, sec_tens, sec_ones}
    logic          paused;
    logic          start_edge;

`ifdef GAME_PAUSE_EN
    assign paused = game_pause;
`else
    assign paused = 1'b0;
`endif

    // A level that is already high when reset is released must not start a
    // round. The armed flag stays low until game_started has been seen low.
    assign start_edge = game_started & ~started_q & armed;

    assign min_ones = time_bcd[11:8];
    assign sec_tens = time_bcd[7:4];
    assign sec_ones = time_bcd[3:0];

    // Map any minute setting onto the supported 1..4 range.
    function automatic logic [3:0] clamp_minutes(input logic [7:0] m);
        if (m == 8'd0)
            return 4'd1;
        else if (m > 8'd4)
            return 4'd4;
        else
            return m[3:0];
    endfunction

    // One-second BCD decrement of M:ST, borrowing through the digits.
    function automatic logic [11:0] bcd_dec(input logic [11:0] t);
        logic [3:0] m, st, so;
        m  = t[11:8];
        st = t[7:4];
        so = t[3:0];
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                m  = m - 4'd1;
            end
        end
        return {m, st, so};
    endfunction

    // Remaining time at or below 0:10.
    function automatic logic warn_zone(input logic [11:0] t);
        return (t[11:8] == 4'd0) &&
               ((t[7:4] == 4'd0) || ((t[7:4] == 4'd1) && (t[3:0] == 4'd0)));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            started_q <= 1'b0;
            armed     <= 1'b0;
            game_done <= 1'b0;
            winner    <= 1'b0;
            running   <= 1'b0;
            warn      <= 1'b0;
            time_bcd  <= 12'h000;
        end else begin
            started_q <= game_started;
            armed     <= armed | ~game_started;

            case (state)
                IDLE: begin
                    if (start_edge)
                        state <= LOAD;
                end

                LOAD: begin
                    time_bcd <= {clamp_minutes(time_setting), 4'd0, 4'd0};
                    presc    <= '0;
                    winner   <= 1'b0;
                    running  <= 1'b1;
                    warn     <= 1'b0;
                    state    <= RUN;
                end

                RUN: begin
                    // Abort wins over every other event while the round runs.
                    if (!game_started) begin
                        running <= 1'b0;
                        warn    <= 1'b0;
                        state   <= IDLE;
                    end else if (seeker_caught) begin
                        game_done <= 1'b1;
                        winner    <= 1'b0;
                        running   <= 1'b0;
                        warn      <= 1'b0;
                        state     <= DONE;
                    end else if (!paused) begin
                        if (presc == PRESC_LAST) begin
                            presc    <= '0;
                            time_bcd <= bcd_dec(time_bcd);
                            if (time_bcd == 12'h001) begin
                                game_done <= 1'b1;
                                winner    <= 1'b1;
                                running   <= 1'b0;
                                warn      <= 1'b0;
                                state     <= DONE;
                            end else begin
                                warn <= warn_zone(bcd_dec(time_bcd));
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (!game_started) begin
                        game_done <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_timer.sv
module tb_game_round_timer;

    localparam int T = 4;

    logic       clk;
    logic       reset;
    logic       game_started;
    logic [7:0] time_setting;
    logic       seeker_caught;
    logic       game_pause;
    logic       game_done;
    logic       winner;
    logic       running;
    logic       warn;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    int errors = 0;
    int checks = 0;

    game_round_timer #(.TICK_CYCLES(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .game_started (game_started),
        .time_setting (time_setting),
        .seeker_caught(seeker_caught),
`ifdef GAME_PAUSE_EN
        .game_pause   (game_pause),
`endif
        .game_done    (game_done),
        .winner       (winner),
        .running      (running),
        .warn         (warn),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the round is a count of remaining seconds plus a
    // count of cycles since the last tick.
    int   m_phase;        // 0 idle, 1 loading, 2 counting, 3 finished
    int   m_secs;
    int   m_cnt;
    bit   m_prev, m_seen_low, m_done, m_win;

    function automatic int clamp_ref(input int ts);
        return (ts == 0) ? 1 : ((ts > 4) ? 4 : ts);
    endfunction

    function automatic logic [11:0] secs_to_bcd(input int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic model_step();
        bit rise, pz;
`ifdef GAME_PAUSE_EN
        pz = game_pause;
`else
        pz = 1'b0;
`endif
        if (reset) begin
            m_phase = 0; m_secs = 0; m_cnt = 0;
            m_prev = 0; m_seen_low = 0; m_done = 0; m_win = 0;
            return;
        end
        rise = game_started && !m_prev && m_seen_low;
        m_prev = game_started;
        if (!game_started) m_seen_low = 1;
        case (m_phase)
            0: if (rise) m_phase = 1;
            1: begin
                m_secs = clamp_ref(int'(time_setting)) * 60;
                m_cnt = 0; m_win = 0; m_phase = 2;
            end
            2: begin
                if (!game_started) m_phase = 0;
                else if (seeker_caught) begin
                    m_done = 1; m_win = 0; m_phase = 3;
                end else if (!pz) begin
                    m_cnt++;
                    if (m_cnt == T) begin
                        m_cnt = 0;
                        m_secs--;
                        if (m_secs == 0) begin
                            m_done = 1; m_win = 1; m_phase = 3;
                        end
                    end
                end
            end
            default: if (!game_started) begin
                m_done = 0; m_phase = 0;
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: model follows the same edge, outputs compared mid-cycle.
    task automatic tick();
        logic [15:0] got, exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        got = {game_done, winner, running, warn, min_ones, sec_tens, sec_ones};
        exp = {m_done, m_win, (m_phase == 2),
               ((m_phase == 2) && (m_secs <= 10)), secs_to_bcd(m_secs)};
        chk("model", 32'(got), 32'(exp));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [11:0] digits();
        return {min_ones, sec_tens, sec_ones};
    endfunction

    task automatic start_round(input logic [7:0] ts);
        game_started = 1'b0;
        tick();
        game_started = 1'b1;
        time_setting = ts;
        ticks(2);
    endtask

    typedef struct {
        logic        rst;
        logic        gs;
        logic [7:0]  ts;
        logic        caught;
        int          n;
        logic        e_run;
        logic        e_done;
        logic        e_win;
        logic [11:0] e_time;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 8'd2, 1'b0, 2, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[1]  = '{1'b0, 1'b1, 8'd2, 1'b0, 5, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[3]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[4]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 12'h100};
        tbl[5]  = '{1'b0, 1'b1, 8'd0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 12'h059};
        tbl[6]  = '{1'b0, 1'b1, 8'd9, 1'b0, 4, 1'b1, 1'b0, 1'b0, 12'h058};
        tbl[7]  = '{1'b0, 1'b1, 8'd9, 1'b1, 1, 1'b0, 1'b1, 1'b0, 12'h058};
        tbl[8]  = '{1'b0, 1'b1, 8'd9, 1'b0, 3, 1'b0, 1'b1, 1'b0, 12'h058};
        tbl[9]  = '{1'b0, 1'b0, 8'd9, 1'b0, 1, 1'b0, 1'b0, 1'b0, 12'h058};
        tbl[10] = '{1'b0, 1'b1, 8'd9, 1'b0, 2, 1'b1, 1'b0, 1'b0, 12'h400};
        tbl[11] = '{1'b0, 1'b0, 8'd9, 1'b0, 1, 1'b0, 1'b0, 1'b0, 12'h400};
        tbl[12] = '{1'b0, 1'b0, 8'd9, 1'b0, 3, 1'b0, 1'b0, 1'b0, 12'h400};

        reset = 1'b1; game_started = 1'b1; time_setting = 8'd2;
        seeker_caught = 1'b0; game_pause = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            reset         = tbl[i].rst;
            game_started  = tbl[i].gs;
            time_setting  = tbl[i].ts;
            seeker_caught = tbl[i].caught;
            for (int k = 0; k < tbl[i].n; k++) tick();
            seeker_caught = 1'b0;
            chk($sformatf("vec%0d_running", i), 32'(running),   32'(tbl[i].e_run));
            chk($sformatf("vec%0d_done", i),    32'(game_done), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d_winner", i),  32'(winner),    32'(tbl[i].e_win));
            chk($sformatf("vec%0d_time", i),    32'(digits()),  32'(tbl[i].e_time));
            if (i <= 1) chk($sformatf("vec%0d_warn", i), 32'(warn), 32'd0);
        end

        // Full expiry from 1:00.
        start_round(8'd1);
        chk("exp_load", 32'(digits()), 32'h100);
        ticks(196);
        chk("exp_0011", 32'(digits()), 32'h011);
        chk("exp_warn_off", 32'(warn), 32'd0);
        ticks(4);
        chk("exp_0010", 32'(digits()), 32'h010);
        chk("exp_warn_on", 32'(warn), 32'd1);
        ticks(39);
        chk("exp_0001", 32'(digits()), 32'h001);
        chk("exp_still_running", 32'(running), 32'd1);
        tick();
        chk("exp_zero", 32'(digits()), 32'h000);
        chk("exp_done", 32'(game_done), 32'd1);
        chk("exp_winner", 32'(winner), 32'd1);
        chk("exp_running", 32'(running), 32'd0);

        // Caught on the same edge as the final tick: seeker wins.
        start_round(8'd1);
        ticks(239);
        chk("sim_0001", 32'(digits()), 32'h001);
        seeker_caught = 1'b1;
        tick();
        seeker_caught = 1'b0;
        chk("sim_done", 32'(game_done), 32'd1);
        chk("sim_winner", 32'(winner), 32'd0);
        chk("sim_time", 32'(digits()), 32'h001);

        // Caught at 2:41.
        start_round(8'd3);
        ticks(76);
        chk("cau_241", 32'(digits()), 32'h241);
        seeker_caught = 1'b1;
        tick();
        seeker_caught = 1'b0;
        chk("cau_done", 32'(game_done), 32'd1);
        chk("cau_winner", 32'(winner), 32'd0);
        ticks(2);
        chk("cau_hold", 32'(digits()), 32'h241);
        game_started = 1'b0;
        tick();
        chk("cau_clear", 32'(game_done), 32'd0);

        // Abort at 0:30.
        start_round(8'd1);
        ticks(120);
        chk("abt_030", 32'(digits()), 32'h030);
        game_started = 1'b0;
        tick();
        chk("abt_running", 32'(running), 32'd0);
        chk("abt_time", 32'(digits()), 32'h030);
        ticks(3);
        chk("abt_no_done", 32'(game_done), 32'd0);
        game_started = 1'b1;
        ticks(2);
        chk("abt_reload", 32'(digits()), 32'h100);
        chk("abt_rerun", 32'(running), 32'd1);

`ifdef GAME_PAUSE_EN
        start_round(8'd1);
        ticks(62);
        chk("pau_045", 32'(digits()), 32'h045);
        game_pause = 1'b1;
        ticks(20);
        chk("pau_hold", 32'(digits()), 32'h045);
        game_pause = 1'b0;
        tick();
        chk("pau_resume1", 32'(digits()), 32'h045);
        tick();
        chk("pau_resume2", 32'(digits()), 32'h044);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) game_started = ~game_started;
            time_setting  = 8'($urandom_range(0, 255));
            seeker_caught = ($urandom_range(0, 79) == 0);
            game_pause    = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_round_timer.md
# game_round_timer

Round timer that sits directly downstream of the menu/settings stage. It consumes `game_started` and `time_setting` (minutes, 1..4), counts a MM:SS round down at 1 Hz, and reports the result. The result is `game_done` plus `winner`, where 1 means hider wins and 0 means seeker wins. These feed straight back into the menu's final-screen selection. It also drives BCD time digits for the seven-segment/OLED overlay.

## Interface
Parameters:
- `TICK_CYCLES`, default 100_000_000: clk cycles per one-second tick (benches use small values).

Ports:
- `clk`  in  1  100 MHz system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `game_started`  in  1  level; high while the menu is in its game state.
- `time_setting`  in  8  round length in minutes; sampled only at round start.
- `seeker_caught`  in  1  single-cycle pulse from game logic when the hider is caught.
- `game_pause`  in  1  present only with `GAME_PAUSE_EN`; level, freezes the countdown.
- `game_done`  out  1  registered level; round over; held until `game_started` falls.
- `winner`  out  1  registered; 1 = hider wins (time expired), 0 = seeker wins (caught).
- `running`  out  1  high in RUN.
- `warn`  out  1  high in RUN while the remaining time is ≤ 0:10.
- `min_ones`  out  4  BCD minutes digit (0..4).
- `sec_tens`  out  4  BCD seconds tens digit (0..5).
- `sec_ones`  out  4  BCD seconds ones digit (0..9).

## Operation
- FSM states are IDLE, LOAD, RUN and DONE.
- IDLE → LOAD: on a rising edge of `game_started`, detected against a registered previous value. A level that is already high out of reset does not start a round.
- LOAD takes one cycle. It latches the clamped minutes and goes to RUN.
  - Clamp rule: 0 → 1; values above 4 → 4.
  - Digits are set to M:00, the prescaler is cleared, and `winner` is cleared to 0.
- RUN: the prescaler counts 0..TICK_CYCLES-1. On wrap, one tick fires and MM:SS is decremented in BCD.
  - Decrement: `sec_ones` 0 → 9 with a borrow from `sec_tens`; `sec_tens` 0 → 5 with a borrow from `min_ones`.
- RUN → DONE on either event:
  - `seeker_caught`: `winner` = 0, digits freeze.
  - A tick taking 0:01 → 0:00: `winner` = 1.
  - If both occur in the same cycle, caught has priority and `winner` = 0.
- RUN → IDLE: if `game_started` is low, the round aborts.
  - `game_done` stays 0.
  - Digits hold their last value; `winner` holds.
- DONE: `game_done` = 1.
  - When `game_started` is low, go to IDLE; `game_done` clears.
  - `seeker_caught` is ignored.
- IDLE: `seeker_caught` is ignored, and digits show the last round's final value.

## Timing
- Reset (synchronous):
  - State IDLE, prescaler 0, `game_started` edge register 0.
  - `game_done`=0, `winner`=0, `running`=0, `warn`=0.
  - Digits 0:00.
- All outputs are registered; no combinational paths from inputs to outputs.
- Start latency: `game_started` first sampled high at edge N; LOAD is active after N, RUN (`running`=1, digits M:00) after N+1.
- First decrement happens TICK_CYCLES cycles after the RUN entry edge; thereafter every TICK_CYCLES cycles.
- Time-expiry end: the edge that writes 0:00 also sets `game_done`=1, `winner`=1, `running`=0.
- Caught end: the edge that samples `seeker_caught`=1 sets `game_done`=1, `winner`=0, `running`=0.
- `warn` updates on the same edge as the digits.
- `game_done` falls on the edge that samples `game_started`=0 in DONE.
- A new round requires a fresh `game_started` rising edge after IDLE is reached.
- `reset` in any state returns to reset values on the next edge and takes priority over all events.

## Configuration
- `GAME_PAUSE_EN` defined:
  - The `game_pause` port exists.
  - While it is high in RUN, the prescaler and digits freeze.
  - Releasing it resumes the prescaler from its held count.
  - `seeker_caught` and a `game_started` abort are still honored during pause.
- `GAME_PAUSE_EN` undefined: the port is absent and the countdown never freezes.

## Test plan
All scenarios use TICK_CYCLES=4.
- Reset: assert `reset` for 2 cycles with `game_started`=1 held → all outputs are 0 and the state stays IDLE with no round start.
- Full expiry: `time_setting`=1, raise `game_started` → digits 1:00 two edges later, 0:59 four cycles after that; after 60 ticks 0:00 with `game_done`=1, `winner`=1 on that edge; `warn` rises at 0:10.
- Caught: `time_setting`=3, pulse `seeker_caught` at 2:41 → `game_done`=1, `winner`=0, digits hold 2:41. Dropping `game_started` clears `game_done` next edge.
- Clamp and simultaneity:
  - `time_setting`=0 loads 1:00; `time_setting`=9 loads 4:00.
  - `seeker_caught` on the 0:01→0:00 tick → `winner`=0.
- Abort: drop `game_started` at 0:30 → IDLE, `game_done` never asserts; a new rising edge reloads M:00.
- With `GAME_PAUSE_EN`: hold `game_pause` for 20 cycles at 0:45 → digits stay 0:45; resume → 0:44 arrives at the remaining prescaler count.
